// File: rtl/byteswap_job_sched_if.sv
// -----------------------------------------------------------------------------
// byteswap_job_sched_if
// Bundles the byteswap job scheduler's signals: the job queue port, the
// control port to the read/write masters, and the status outputs.
//   slave  : scheduler view (accepts jobs, drives ctrl/status)
//   master : producer/master-side view (offers jobs, returns done pulses)
// The optional timeout_err output exists only with BYTESWAP_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
interface byteswap_job_sched_if #(
  parameter int C_ADDR_WIDTH   = 64,
  parameter int C_LENGTH_WIDTH = 32,
  parameter int C_QUEUE_DEPTH  = 4,
  parameter int C_COUNT_WIDTH  = 32
);
  localparam int QCNT_W = $clog2(C_QUEUE_DEPTH) + 1;

  // Job queue port
  logic                      job_valid;
  logic                      job_ready;
  logic [C_ADDR_WIDTH-1:0]   job_offset;
  logic [C_LENGTH_WIDTH-1:0] job_length;
  // Control port to both masters
  logic                      ctrl_start;
  logic [C_ADDR_WIDTH-1:0]   ctrl_offset;
  logic [C_LENGTH_WIDTH-1:0] ctrl_length;
  logic                      rd_done;
  logic                      wr_done;
  // Status
  logic                      job_done;
  logic                      busy;
  logic [QCNT_W-1:0]         queue_count;
  logic [C_COUNT_WIDTH-1:0]  jobs_done_count;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
  logic                      timeout_err;
`endif

  modport slave (
    input  job_valid, job_offset, job_length, rd_done, wr_done,
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
    output timeout_err,
`endif
    output job_ready, ctrl_start, ctrl_offset, ctrl_length,
           job_done, busy, queue_count, jobs_done_count
  );

  modport master (
    output job_valid, job_offset, job_length, rd_done, wr_done,
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
    input  timeout_err,
`endif
    input  job_ready, ctrl_start, ctrl_offset, ctrl_length,
           job_done, busy, queue_count, jobs_done_count
  );
endinterface

// File: rtl/byteswap_job_sched.sv
// -----------------------------------------------------------------------------
// byteswap_job_sched
// Job scheduler in front of the byteswap datapath. Jobs (offset, length) are
// queued in a small FIFO and issued one at a time to the read and write
// masters with a single-cycle ctrl_start pulse. A job retires once both
// masters have reported done; zero-length jobs retire without being issued.
//
// Ports:
//   ap_clk  : sole clock, rising edge
//   areset  : synchronous, active-high reset (shared with the masters)
//   bus     : byteswap_job_sched_if.slave -- job queue, ctrl and status
//
// Optional feature macro: BYTESWAP_SCHED_TIMEOUT_EN
//   Adds bus.timeout_err and a WAIT watchdog of C_TIMEOUT_CYCLES cycles that
//   force-retires a stuck job and sets timeout_err until reset.
// -----------------------------------------------------------------------------
module byteswap_job_sched #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_LENGTH_WIDTH   = 32,
  parameter int C_QUEUE_DEPTH    = 4,
  parameter int C_COUNT_WIDTH    = 32
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
  ,
  parameter int C_TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  byteswap_job_sched_if.slave  bus
);

  localparam int PTR_W   = $clog2(C_QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = C_ADDR_WIDTH + C_LENGTH_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RETIRE} state_e;

  // FIFO
  logic [ENTRY_W-1:0]        mem_q [C_QUEUE_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      job_ready_q;
  logic                      push, pop, fifo_empty;
  logic [C_ADDR_WIDTH-1:0]   head_offset;
  logic [C_LENGTH_WIDTH-1:0] head_length;

  // FSM and registered outputs
  state_e                    state_q;
  logic                      ctrl_start_q, job_done_q;
  logic [C_ADDR_WIDTH-1:0]   ctrl_offset_q;
  logic [C_LENGTH_WIDTH-1:0] ctrl_length_q;
  logic                      rd_seen_q, wr_seen_q, both_done;
  logic [C_COUNT_WIDTH-1:0]  jobs_done_q;

`ifdef BYTESWAP_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]          timer_q;
  logic                      timeout_err_q;
`endif

  assign fifo_empty = (count_q == '0);
  // job_ready is registered, so a push never relies on a same-cycle pop.
  assign push       = bus.job_valid && job_ready_q;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign {head_offset, head_length} = mem_q[rd_ptr_q];
  // A done arriving this cycle counts together with one latched earlier.
  assign both_done  = (rd_seen_q || bus.rd_done) && (wr_seen_q || bus.wr_done);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // NOTE: the storage array carries no reset; the pointers and occupancy
  // define which entries are valid, so flushing only needs those reset.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.job_offset, bus.job_length};
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      job_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      job_ready_q <= (count_d != CNT_W'(C_QUEUE_DEPTH));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      ctrl_start_q  <= 1'b0;
      job_done_q    <= 1'b0;
      ctrl_offset_q <= '0;
      ctrl_length_q <= '0;
      rd_seen_q     <= 1'b0;
      wr_seen_q     <= 1'b0;
      jobs_done_q   <= '0;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // Pulses are asserted on the transition into START/RETIRE and drop here.
      ctrl_start_q <= 1'b0;
      job_done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            ctrl_offset_q <= head_offset;
            ctrl_length_q <= head_length;
            if (head_length != '0) begin
              state_q      <= S_START;
              ctrl_start_q <= 1'b1;
            end else begin
              // Zero-length job: retire without involving the masters.
              state_q     <= S_RETIRE;
              job_done_q  <= 1'b1;
              jobs_done_q <= jobs_done_q + C_COUNT_WIDTH'(1);
            end
          end
        end
        S_START: begin
          // Dones seen before the masters were started are stale.
          rd_seen_q <= 1'b0;
          wr_seen_q <= 1'b0;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
          timer_q   <= '0;
`endif
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rd_done) rd_seen_q <= 1'b1;
          if (bus.wr_done) wr_seen_q <= 1'b1;
          if (both_done) begin
            state_q     <= S_RETIRE;
            job_done_q  <= 1'b1;
            jobs_done_q <= jobs_done_q + C_COUNT_WIDTH'(1);
          end
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
          else if (timer_q == TMR_W'(C_TIMEOUT_CYCLES - 1)) begin
            // Watchdog: the job has sat in WAIT for C_TIMEOUT_CYCLES cycles.
            state_q       <= S_RETIRE;
            job_done_q    <= 1'b1;
            jobs_done_q   <= jobs_done_q + C_COUNT_WIDTH'(1);
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
`endif
        end
        S_RETIRE: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.job_ready       = job_ready_q;
  assign bus.ctrl_start      = ctrl_start_q;
  assign bus.ctrl_offset     = ctrl_offset_q;
  assign bus.ctrl_length     = ctrl_length_q;
  assign bus.job_done        = job_done_q;
  assign bus.busy            = (state_q != S_IDLE) || !fifo_empty;
  assign bus.queue_count     = count_q;
  assign bus.jobs_done_count = jobs_done_q;
`ifdef BYTESWAP_SCHED_TIMEOUT_EN
  assign bus.timeout_err     = timeout_err_q;
`endif

endmodule
